// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the multicycle fetch unit.
// The optional misaligned-branch-target check is enabled by defining
// MISALIGN_CHK_EN when compiling pc_fetch_ctrl.
package pc_fetch_pkg;

  // Fetch sequencer states. HALT is only reachable when the misalignment
  // check is compiled in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

  // Sequential PC increment: one 32-bit instruction word per fetch.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch unit.
// Produces either the sequential successor (PC + PC_STEP) or the branch
// target (PC + ImmOp). Both sums are ADDR_WIDTH bits wide and wrap modulo
// 2^ADDR_WIDTH. Also flags a branch target that is not word aligned.
module pc_next_calc
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] imm,
  input  logic                  pcsrc,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misalign
);

  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] branch_pc;

  // imm is two's complement, so a plain modular add covers backward
  // branches as well; the carry out is intentionally dropped.
  assign seq_pc    = pc + ADDR_WIDTH'(PC_STEP);
  assign branch_pc = pc + imm;

  assign next_pc  = pcsrc ? branch_pc : seq_pc;

  // Only a taken branch can land off a word boundary; the sequential path
  // preserves alignment by construction.
  assign misalign = pcsrc && (branch_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Multicycle instruction fetch sequencer.
// Holds the PC, issues one ROM read per instruction, hands the fetched word
// to decode over a valid/ready handshake and advances the PC only when
// decode accepts. A read that is not acknowledged within TIMEOUT WAIT cycles
// is re-issued at the same PC.
// Optional feature: define MISALIGN_CHK_EN to trap taken branches whose
// target is not word aligned (sticky err, terminal HALT state until rst).
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  err
);

  // Timer counts completed WAIT cycles, 0 .. TIMEOUT-1.
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

`ifdef MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  fetch_state_e          state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  misalign;
  logic                  bad_target;

  pc_next_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next (
    .pc       (pc_q),
    .imm      (ImmOp),
    .pcsrc    (PCsrc),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  // With the check compiled out this is constant 0, so HALT is unreachable
  // and err never leaves its reset value.
  assign bad_target = CHK_EN && misalign;

  // Next-state, timer, PC and holding-register update for the fetch FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    mem_req = 1'b0;

    case (state_q)
      IDLE: begin
        // One dead cycle after reset before the first read goes out.
        state_d = REQ;
      end

      REQ: begin
        mem_req = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // An ack in the timeout cycle still counts: the response wins over
        // the re-issue.
        if (mem_ack) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (timer_q == TIMER_LAST) begin
          state_d = REQ;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      HOLD: begin
        // mem_ack is ignored here: a stale or duplicate response must not
        // overwrite the word decode is looking at.
        if (instr_ready) begin
          valid_d = 1'b0;
          if (bad_target) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end

      HALT: begin
        // Terminal until rst; nothing is requested or presented.
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pc_q    <= '0;
      // NOTE: the instruction holding register is reset too, since decode
      // may observe instr while instr_valid is low.
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr    = pc_q;
  assign PC          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (ADDR_WIDTH=8,
// DATA_WIDTH=32, TIMEOUT=7). Inputs are driven and outputs sampled 1 time
// unit after each rising clock edge. Build with MISALIGN_CHK_EN defined to
// exercise the trapping variant of the misaligned-branch scenario.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        PCsrc;
  logic [7:0]  ImmOp;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  PC;
  logic        err;

  int errors = 0;
  int checks = 0;

  // ROM responder bookkeeping: ack the cycle after a request was seen.
  bit         auto_ack = 1'b0;
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  pc_fetch_ctrl #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .TIMEOUT    (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PC          (PC),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {16'hC0DE, 8'h5A, a};
  endfunction

  // Advance one clock; sample point is 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      mem_ack   = prev_req;
      mem_rdata = prev_req ? rom_word(prev_addr) : 32'hDEAD_BEEF;
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmOp       = 8'h00;
    mem_ack     = 1'b0;
    step();
    step();
    rst      = 1'b0;
    prev_req = 1'b0;
  endtask

  task automatic wait_hold(input int max_cycles);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold: instr_valid=%b after %0d cycles, required 1", instr_valid, n);
    end
  endtask

  // Present a one-cycle accept with the given branch controls.
  task automatic accept(input logic src, input logic [7:0] imm);
    instr_ready = 1'b1;
    PCsrc       = src;
    ImmOp       = imm;
    step();
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmOp       = 8'hA5;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    mem_ack = 1'b0;
    checks++;
    if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h, required 00", PC); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", mem_req); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, required 0", instr); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    rst = 1'b0;
  endtask

  // Ack 1 cycle after each req, ready always high: req every 3 cycles.
  task automatic test_sequential();
    do_reset();
    auto_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (mem_req !== ((i % 3) == 1)) begin
        errors++;
        $display("FAIL seq_req cycle %0d: got %b, required %b", i, mem_req, (i % 3) == 1);
      end
      if ((i % 3) == 1) begin
        checks++;
        if (mem_addr !== 8'((i - 1) / 3 * 4)) begin
          errors++;
          $display("FAIL seq_addr cycle %0d: got %h, required %h", i, mem_addr, 8'((i - 1) / 3 * 4));
        end
      end
      if ((i % 3) == 0) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== rom_word(8'((i - 3) / 3 * 4))) begin
          errors++;
          $display("FAIL seq_instr cycle %0d: got valid=%b %h, required 1 %h",
                   i, instr_valid, instr, rom_word(8'((i - 3) / 3 * 4)));
        end
      end
    end
    instr_ready = 1'b0;
  endtask

  // HOLD with ready low: word and PC frozen, acks ignored, no request.
  task automatic test_stall();
    do_reset();
    auto_ack = 1'b1;
    wait_hold(20);
    auto_ack  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== rom_word(8'h00) || PC !== 8'h00 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: got valid=%b instr=%h pc=%h req=%b, required 1 %h 00 0",
                 i, instr_valid, instr, PC, mem_req, rom_word(8'h00));
      end
    end
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h04 || PC !== 8'h04 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%h pc=%h valid=%b, required 1 04 04 0",
               mem_req, mem_addr, PC, instr_valid);
    end
    auto_ack = 1'b1;
  endtask

  task automatic test_branch();
    do_reset();
    auto_ack = 1'b1;
    wait_hold(20);
    for (int k = 0; k < 4; k++) begin
      accept(1'b0, 8'h55);
      wait_hold(20);
    end
    checks++;
    if (PC !== 8'h10) begin errors++; $display("FAIL branch_setup_pc: got %h, required 10", PC); end
    accept(1'b1, 8'hF8);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h08) begin
      errors++;
      $display("FAIL branch_back: got req=%b addr=%h, required 1 08", mem_req, mem_addr);
    end
    wait_hold(20);
    accept(1'b1, 8'hF4);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'hFC) begin
      errors++;
      $display("FAIL branch_to_fc: got req=%b addr=%h, required 1 fc", mem_req, mem_addr);
    end
    wait_hold(20);
    accept(1'b0, 8'h33);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL seq_wrap: got req=%b addr=%h, required 1 00", mem_req, mem_addr);
    end
  endtask

  // No ack: 7 WAIT cycles, then re-issue at the same PC; then an ack in
  // the final WAIT cycle of the second attempt wins over the re-issue.
  task automatic test_timeout();
    do_reset();
    auto_ack = 1'b0;
    mem_ack  = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL to_first_req: got req=%b addr=%h, required 1 00", mem_req, mem_addr);
    end
    for (int w = 0; w < 7; w++) begin
      step();
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL to_wait cycle %0d: got req=%b, required 0", w, mem_req);
      end
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL to_reissue: got req=%b addr=%h, required 1 00", mem_req, mem_addr);
    end
    for (int w = 0; w < 7; w++) step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFEED_0001;
    step();
    mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hFEED_0001 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_late_ack: got valid=%b instr=%h req=%b, required 1 feed0001 0",
               instr_valid, instr, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL to_hold_after: got req=%b valid=%b, required 0 1", mem_req, instr_valid);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    auto_ack = 1'b0;
    step();
    step();
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    step();
    rst = 1'b0;
    checks++;
    if (PC !== 8'h00 || instr_valid !== 1'b0 || mem_req !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_wait: got pc=%h valid=%b req=%b instr=%h, required 00 0 0 0",
               PC, instr_valid, mem_req, instr);
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || instr !== 32'h0) begin
      errors++;
      $display("FAIL idle_ack_ignored: got valid=%b req=%b instr=%h, required 0 1 0",
               instr_valid, mem_req, instr);
    end
    auto_ack = 1'b1;
    wait_hold(20);
    accept(1'b0, 8'h00);
    wait_hold(20);
    checks++;
    if (PC !== 8'h04) begin errors++; $display("FAIL rst_hold_setup: got pc=%h, required 04", PC); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (PC !== 8'h00 || instr_valid !== 1'b0 || instr !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_hold: got pc=%h valid=%b instr=%h req=%b, required 00 0 0 0",
               PC, instr_valid, instr, mem_req);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    auto_ack = 1'b1;
    wait_hold(20);
    accept(1'b1, 8'h20);
    checks++;
    if (mem_addr !== 8'h20 || err !== 1'b0) begin
      errors++;
      $display("FAIL mis_setup: got addr=%h err=%b, required 20 0", mem_addr, err);
    end
    wait_hold(20);
    accept(1'b1, 8'h02);
`ifdef MISALIGN_CHK_EN
    checks++;
    if (err !== 1'b1 || PC !== 8'h20 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_trap: got err=%b pc=%h req=%b valid=%b, required 1 20 0 0",
               err, PC, mem_req, instr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (err !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || PC !== 8'h20) begin
        errors++;
        $display("FAIL mis_halt cycle %0d: got err=%b req=%b valid=%b pc=%h, required 1 0 0 20",
                 i, err, mem_req, instr_valid, PC);
      end
    end
`else
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h22 || err !== 1'b0) begin
      errors++;
      $display("FAIL mis_passthru: got req=%b addr=%h err=%b, required 1 22 0", mem_req, mem_addr, err);
    end
`endif
  endtask

  initial begin
    rst         = 1'b1;
    PCsrc       = 1'b0;
    ImmOp       = 8'h00;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_timeout();
    test_rst_mid();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
